// File: rtl/mem_pkg.sv
// Shared funct3 codes, FSM state type and byte-lane constants for the load/store unit.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Big-endian lanes: byte offset 0 lives in bits [31:24] and be[3].
  localparam logic [3:0] BE_BYTE0 = 4'b1000;
  localparam logic [3:0] BE_HALF0 = 4'b1100;
  localparam logic [3:0] BE_HALF1 = 4'b0011;
  localparam logic [3:0] BE_WORD  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic f3_legal(input logic store, input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LH, F3_LW: return 1'b1;
      F3_LBU, F3_LHU:      return !store;
      default:             return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] align_addr(input logic [2:0] f3, input logic [31:0] addr);
    case (f3[1:0])
      SZ_HALF: return {addr[31:1], 1'b0};
      SZ_WORD: return {addr[31:2], 2'b00};
      default: return addr;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational byte-lane formatter: store byte enables/replication and load extraction.
module mem_lane_fmt
  import mem_pkg::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_data,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_ld_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_st_wdata,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic        w_ld_sext;

  always_comb begin
    o_be       = BE_WORD;
    o_st_wdata = i_st_data;
    case (i_st_size)
      SZ_BYTE: begin
        o_be       = BE_BYTE0 >> i_st_off;
        o_st_wdata = {4{i_st_data[7:0]}};
      end
      SZ_HALF: begin
        o_be       = i_st_off[1] ? BE_HALF1 : BE_HALF0;
        o_st_wdata = {2{i_st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_ld_byte = i_ld_rdata[7:0];
    case (i_ld_off)
      2'd0:    w_ld_byte = i_ld_rdata[31:24];
      2'd1:    w_ld_byte = i_ld_rdata[23:16];
      2'd2:    w_ld_byte = i_ld_rdata[15:8];
      default: w_ld_byte = i_ld_rdata[7:0];
    endcase
    w_ld_half = i_ld_off[1] ? i_ld_rdata[15:0] : i_ld_rdata[31:16];
    // funct3[2] set means the unsigned variant.
    w_ld_sext = !i_ld_funct3[2];
    case (i_ld_funct3[1:0])
      SZ_BYTE: o_ld_data = {{24{w_ld_sext & w_ld_byte[7]}}, w_ld_byte};
      SZ_HALF: o_ld_data = {{16{w_ld_sext & w_ld_half[15]}}, w_ld_half};
      default: o_ld_data = i_ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: one outstanding RV32 memory op, big-endian lanes, bus timeout.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign,
  output logic        bus_err,
  output logic        illegal_op,
  output logic [31:0] err_addr
);

  // state | meaning
  // IDLE  | ex_ready high, waiting for an op
  // REQ   | mem_req held stable, timeout counter running down
  // RESP  | load result on wb_* for exactly one cycle

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t             r_state;
  logic               r_store;
  logic [2:0]         r_funct3;
  logic [31:0]        r_addr;
  logic [4:0]         r_rd;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_mem_req;
  logic               r_mem_we;
  logic [31:0]        r_mem_addr;
  logic [3:0]         r_mem_be;
  logic [31:0]        r_mem_wdata;
  logic               r_wb_valid;
  logic [4:0]         r_wb_rd;
  logic [31:0]        r_wb_data;
  logic               r_misalign;
  logic               r_bus_err;
  logic               r_illegal_op;
  logic [31:0]        r_err_addr;

  logic               w_legal;
  logic               w_trap;
  logic [31:0]        w_addr_eff;
  logic [3:0]         w_be;
  logic [31:0]        w_st_wdata;
  logic [31:0]        w_ld_data;

  assign w_legal    = f3_legal(ex_store, ex_funct3);
  assign w_addr_eff = align_addr(ex_funct3, ex_addr);

`ifdef MISALIGN_TRAP_EN
  assign w_trap = is_misaligned(ex_funct3, ex_addr[1:0]);
`else
  assign w_trap = 1'b0;
`endif

  mem_lane_fmt u_lane_fmt (
    .i_st_size   (ex_funct3[1:0]),
    .i_st_off    (w_addr_eff[1:0]),
    .i_st_data   (ex_wdata),
    .i_ld_funct3 (r_funct3),
    .i_ld_off    (r_addr[1:0]),
    .i_ld_rdata  (mem_rdata),
    .o_be        (w_be),
    .o_st_wdata  (w_st_wdata),
    .o_ld_data   (w_ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_store      <= 1'b0;
      r_funct3     <= 3'b000;
      r_addr       <= '0;
      r_rd         <= '0;
      r_cnt        <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_be     <= '0;
      r_mem_wdata  <= '0;
      r_wb_valid   <= 1'b0;
      r_wb_rd      <= '0;
      r_wb_data    <= '0;
      r_misalign   <= 1'b0;
      r_bus_err    <= 1'b0;
      r_illegal_op <= 1'b0;
      r_err_addr   <= '0;
    end else begin
      r_wb_valid   <= 1'b0;
      r_misalign   <= 1'b0;
      r_bus_err    <= 1'b0;
      r_illegal_op <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (ex_valid) begin
            if (!w_legal) begin
              r_illegal_op <= 1'b1;
            end else if (w_trap) begin
              r_misalign <= 1'b1;
              r_err_addr <= ex_addr;
            end else begin
              r_store     <= ex_store;
              r_funct3    <= ex_funct3;
              r_addr      <= w_addr_eff;
              r_rd        <= ex_rd;
              r_cnt       <= CNT_W'(TIMEOUT_CYCLES);
              r_mem_req   <= 1'b1;
              r_mem_we    <= ex_store;
              r_mem_addr  <= {w_addr_eff[31:2], 2'b00};
              r_mem_be    <= w_be;
              r_mem_wdata <= ex_store ? w_st_wdata : '0;
              r_state     <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          // An ack in the final counted cycle still completes normally.
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (r_store) begin
              r_state <= ST_IDLE;
            end else begin
              r_wb_valid <= 1'b1;
              r_wb_rd    <= r_rd;
              r_wb_data  <= w_ld_data;
              r_state    <= ST_RESP;
            end
          end else if (r_cnt == CNT_W'(1)) begin
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_bus_err  <= 1'b1;
            r_err_addr <= r_addr;
            r_state    <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ex_ready   = (r_state == ST_IDLE);
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_be     = r_mem_be;
  assign mem_wdata  = r_mem_wdata;
  assign wb_valid   = r_wb_valid;
  assign wb_rd      = r_wb_rd;
  assign wb_data    = r_wb_data;
  assign misalign   = r_misalign;
  assign bus_err    = r_bus_err;
  assign illegal_op = r_illegal_op;
  assign err_addr   = r_err_addr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table plus scoreboard queues.
// Expectations for misaligned ops follow MISALIGN_TRAP_EN.
module tb_mem_access_unit;

  localparam int TO = 16;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready, ex_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign, bus_err, illegal_op;
  logic [31:0] err_addr;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_store(ex_store), .ex_funct3(ex_funct3),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign(misalign), .bus_err(bus_err), .illegal_op(illegal_op), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    int          lat;
    bit          has_req;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] mwdata;
    bit          has_wb;
    logic [31:0] wbd;
    int          evt;
    logic [31:0] eaddr;
  } vec_t;

  typedef struct { logic [31:0] maddr; logic [3:0] be; logic [31:0] wdata; logic we; } req_exp_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; } wb_exp_t;
  typedef struct { int kind; logic [31:0] addr; } evt_exp_t;

  req_exp_t req_q[$];
  wb_exp_t  wb_q[$];
  evt_exp_t evt_q[$];
  vec_t     vecs[$];

  int checks   = 0;
  int failures = 0;
  int ack_lat  = 0;
  bit resp_en  = 1'b1;
  bit mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h40:  return 32'h8899_AABB;
      32'h44:  return 32'h0123_4567;
      32'h48:  return 32'h7F80_FF00;
      default: return 32'h0;
    endcase
  endfunction

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [4:0] rd, input int lat,
                              input bit has_req, input logic [31:0] maddr, input logic [3:0] be,
                              input logic [31:0] mwdata, input bit has_wb, input logic [31:0] wbd,
                              input int evt, input logic [31:0] eaddr);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd; v.lat = lat;
    v.has_req = has_req; v.maddr = maddr; v.be = be; v.mwdata = mwdata;
    v.has_wb = has_wb; v.wbd = wbd; v.evt = evt; v.eaddr = eaddr;
    return v;
  endfunction

  // Memory responder: ack in the ack_lat-th REQ cycle, never when ack_lat is 0.
  int rsp_cnt = 0;
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (resp_en) begin
        if (mem_req) begin
          rsp_cnt++;
          mem_ack   = (ack_lat != 0) && (rsp_cnt == ack_lat);
          mem_rdata = mem_ack ? mem_word(mem_addr) : 32'h0;
        end else begin
          rsp_cnt   = 0;
          mem_ack   = 1'b0;
          mem_rdata = 32'h0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT produces a request, writeback or error pulse.
  logic     prev_req = 1'b0, prev_wb = 1'b0;
  int       req_len = 0, last_req_len = 0;
  req_exp_t re;
  wb_exp_t  we_exp;
  evt_exp_t ee;
  logic [3:1] flags;
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_req && !prev_req) begin
        check("req_expected", 32'(req_q.size() != 0), 32'd1);
        if (req_q.size() != 0) begin
          re = req_q.pop_front();
          check("mem_addr", mem_addr, re.maddr);
          check("mem_be", 32'(mem_be), 32'(re.be));
          check("mem_wdata", mem_wdata, re.wdata);
          check("mem_we", 32'(mem_we), 32'(re.we));
        end
      end
      if (mem_req) req_len++;
      else if (prev_req) begin
        last_req_len = req_len;
        req_len = 0;
      end
      if (wb_valid) begin
        check("wb_one_cycle", 32'(prev_wb), 32'd0);
        check("wb_expected", 32'(wb_q.size() != 0), 32'd1);
        if (wb_q.size() != 0) begin
          we_exp = wb_q.pop_front();
          check("wb_rd", 32'(wb_rd), 32'(we_exp.rd));
          check("wb_data", wb_data, we_exp.data);
        end
      end
      flags = {illegal_op, bus_err, misalign};
      for (int k = 1; k <= 3; k++) begin
        if (flags[k]) begin
          check("evt_expected", 32'(evt_q.size() != 0), 32'd1);
          if (evt_q.size() != 0) begin
            ee = evt_q.pop_front();
            check("evt_kind", 32'(k), 32'(ee.kind));
            if (k != 3) check("err_addr", err_addr, ee.addr);
            if (k == 2) check("timeout_len", 32'(last_req_len), 32'(TO));
          end
        end
      end
    end
    prev_req = mem_req;
    prev_wb  = wb_valid;
  end

  task automatic drive_op(input vec_t v);
    req_exp_t r;
    wb_exp_t  w;
    evt_exp_t e;
    ack_lat = v.lat;
    if (v.has_req) begin
      r.maddr = v.maddr; r.be = v.be; r.wdata = v.mwdata; r.we = v.st;
      req_q.push_back(r);
    end
    if (v.has_wb) begin
      w.rd = v.rd; w.data = v.wbd;
      wb_q.push_back(w);
    end
    if (v.evt != 0) begin
      e.kind = v.evt; e.addr = v.eaddr;
      evt_q.push_back(e);
    end
    @(negedge clk);
    check("ex_ready_idle", 32'(ex_ready), 32'd1);
    ex_valid = 1'b1; ex_store = v.st; ex_funct3 = v.f3;
    ex_addr = v.addr; ex_wdata = v.wdata; ex_rd = v.rd;
    @(negedge clk);
    ex_valid = 1'b0;
  endtask

  task automatic drain_check(input string tag);
    check({tag, "_req_drained"}, 32'(req_q.size()), 32'd0);
    check({tag, "_wb_drained"}, 32'(wb_q.size()), 32'd0);
    check({tag, "_evt_drained"}, 32'(evt_q.size()), 32'd0);
    req_q.delete(); wb_q.delete(); evt_q.delete();
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    drive_op(v);
    repeat (((v.lat == 0) ? TO : v.lat) + 4) @(negedge clk);
    drain_check($sformatf("vec%0d", idx));
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; ex_store = 1'b0; ex_funct3 = 3'b0;
    ex_addr = 32'h0; ex_wdata = 32'h0; ex_rd = 5'd0;

    //     st f3    addr     wdata          rd lat req maddr  be       mwdata         wb wbd            evt eaddr
    vecs.push_back(mk(0, LB,  32'h41, 32'hFFFF_FFFF, 5,  1, 1, 32'h40, 4'b0100, 32'h0,         1, 32'hFFFF_FF99, 0, 0));
    vecs.push_back(mk(0, LBU, 32'h43, 32'hFFFF_FFFF, 6,  2, 1, 32'h40, 4'b0001, 32'h0,         1, 32'h0000_00BB, 0, 0));
    vecs.push_back(mk(0, LH,  32'h42, 32'hFFFF_FFFF, 7,  1, 1, 32'h40, 4'b0011, 32'h0,         1, 32'hFFFF_AABB, 0, 0));
    vecs.push_back(mk(0, LW,  32'h40, 32'hFFFF_FFFF, 8,  3, 1, 32'h40, 4'b1111, 32'h0,         1, 32'h8899_AABB, 0, 0));
    vecs.push_back(mk(0, LHU, 32'h48, 32'hFFFF_FFFF, 9,  1, 1, 32'h48, 4'b1100, 32'h0,         1, 32'h0000_7F80, 0, 0));
    vecs.push_back(mk(0, LB,  32'h49, 32'hFFFF_FFFF, 10, 2, 1, 32'h48, 4'b0100, 32'h0,         1, 32'hFFFF_FF80, 0, 0));
    vecs.push_back(mk(0, LHU, 32'h42, 32'hFFFF_FFFF, 11, 1, 1, 32'h40, 4'b0011, 32'h0,         1, 32'h0000_AABB, 0, 0));
    vecs.push_back(mk(1, SH,  32'h42, 32'h0000_1234, 0,  1, 1, 32'h40, 4'b0011, 32'h1234_1234, 0, 0, 0, 0));
    vecs.push_back(mk(1, SB,  32'h45, 32'hABCD_EF5A, 0,  2, 1, 32'h44, 4'b0100, 32'h5A5A_5A5A, 0, 0, 0, 0));
    vecs.push_back(mk(1, SW,  32'h48, 32'hDEAD_BEEF, 0,  1, 1, 32'h48, 4'b1111, 32'hDEAD_BEEF, 0, 0, 0, 0));
    vecs.push_back(mk(1, SH,  32'h44, 32'h0000_CAFE, 0,  1, 1, 32'h44, 4'b1100, 32'hCAFE_CAFE, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b011, 32'h40, 32'h0,      1,  1, 0, 32'h0,  4'b0000, 32'h0,         0, 0, 3, 0));
    vecs.push_back(mk(1, 3'b100, 32'h40, 32'h0,      0,  1, 0, 32'h0,  4'b0000, 32'h0,         0, 0, 3, 0));
    vecs.push_back(mk(0, 3'b110, 32'h40, 32'h0,      2,  1, 0, 32'h0,  4'b0000, 32'h0,         0, 0, 3, 0));
    vecs.push_back(mk(1, 3'b101, 32'h44, 32'h0,      0,  1, 0, 32'h0,  4'b0000, 32'h0,         0, 0, 3, 0));
    vecs.push_back(mk(0, 3'b111, 32'h44, 32'h0,      3,  1, 0, 32'h0,  4'b0000, 32'h0,         0, 0, 3, 0));
`ifdef MISALIGN_TRAP_EN
    vecs.push_back(mk(0, LW,  32'h42, 32'h0,         16, 1, 0, 32'h0,  4'b0000, 32'h0,         0, 0, 1, 32'h42));
    vecs.push_back(mk(0, LH,  32'h45, 32'h0,         17, 1, 0, 32'h0,  4'b0000, 32'h0,         0, 0, 1, 32'h45));
    vecs.push_back(mk(1, SW,  32'h41, 32'hCAFE_F00D, 0,  1, 0, 32'h0,  4'b0000, 32'h0,         0, 0, 1, 32'h41));
`else
    vecs.push_back(mk(0, LW,  32'h42, 32'h0,         16, 1, 1, 32'h40, 4'b1111, 32'h0,         1, 32'h8899_AABB, 0, 0));
    vecs.push_back(mk(0, LH,  32'h45, 32'h0,         17, 1, 1, 32'h44, 4'b1100, 32'h0,         1, 32'h0000_0123, 0, 0));
    vecs.push_back(mk(1, SW,  32'h41, 32'hCAFE_F00D, 0,  1, 1, 32'h40, 4'b1111, 32'hCAFE_F00D, 0, 0, 0, 0));
`endif
    vecs.push_back(mk(0, LW,  32'h44, 32'h0,         13, 0,  1, 32'h44, 4'b1111, 32'h0,         0, 0, 2, 32'h44));
    vecs.push_back(mk(0, LW,  32'h44, 32'h0,         14, 16, 1, 32'h44, 4'b1111, 32'h0,         1, 32'h0123_4567, 0, 0));
    vecs.push_back(mk(0, LW,  32'h48, 32'h0,         15, 15, 1, 32'h48, 4'b1111, 32'h0,         1, 32'h7F80_FF00, 0, 0));
    vecs.push_back(mk(1, SB,  32'h43, 32'h0000_00A5, 0,  0,  1, 32'h40, 4'b0001, 32'hA5A5_A5A5, 0, 0, 2, 32'h43));

    repeat (2) @(negedge clk);
    check("rst_ex_ready", 32'(ex_ready), 32'd1);
    check("rst_ctl", {26'd0, mem_req, mem_we, wb_valid, misalign, bus_err, illegal_op}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_err_addr", err_addr, 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Stray ack while idle must be ignored.
    resp_en = 1'b0;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    repeat (3) @(negedge clk);
    check("stray_ack_ready", 32'(ex_ready), 32'd1);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    resp_en = 1'b1;
    run_vec(mk(0, LW, 32'h40, 32'h0, 20, 2, 1, 32'h40, 4'b1111, 32'h0, 1, 32'h8899_AABB, 0, 0), 100);

    // Reset two cycles into REQ aborts the op.
    drive_op(mk(0, LW, 32'h48, 32'h0, 21, 0, 1, 32'h48, 4'b1111, 32'h0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_mem_req", 32'(mem_req), 32'd0);
    check("abort_ex_ready", 32'(ex_ready), 32'd1);
    check("abort_wb_valid", 32'(wb_valid), 32'd0);
    check("abort_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (TO + 4) @(negedge clk);
    drain_check("abort");

    run_vec(mk(0, LB, 32'h40, 32'h0, 22, 1, 1, 32'h40, 4'b1000, 32'h0, 1, 32'hFFFF_FF88, 0, 0), 101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
